// File: rtl/writeback_prim_assembler_pkg.sv
// Shared opcode encodings, primitive-mode values and assembler state type
// for the writeback / primitive-assembly stage.
package writeback_prim_assembler_pkg;

    localparam int OPCODE_WIDTH     = 8;
    localparam int VERTEX_REG_WIDTH = 30;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP            = 8'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEGINPRIMITIVE = 8'hA0;
    localparam logic [OPCODE_WIDTH-1:0] OP_SETVERTEX      = 8'hA1;
    localparam logic [OPCODE_WIDTH-1:0] OP_ENDPRIMITIVE   = 8'hA2;

    localparam logic PRIM_MODE_LIST  = 1'b0;
    localparam logic PRIM_MODE_STRIP = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } asm_state_e;

endpackage

// File: rtl/writeback_prim_assembler_prim_fifo.sv
// Small synchronous FIFO holding completed primitives; a push while full is
// accepted only if a pop frees a slot on the same edge.
module prim_fifo #(
    parameter int WIDTH = 90,
    parameter int DEPTH = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rdPtr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(negedge i_clock) begin
        if (w_push && !i_reset) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(negedge i_clock) begin
        if (i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/writeback_prim_assembler.sv
// Writeback stage: returns results to decode one edge later and assembles
// SETVERTEX values into list/strip primitives queued for the GPU stage.
module writeback_prim_assembler
    import writeback_prim_assembler_pkg::*;
#(
    parameter int REG_WIDTH       = 16,
    parameter int VREG_WIDTH      = 64,
    parameter int VREG_ID_WIDTH   = 6,
    parameter int VERTEX_WIDTH    = VERTEX_REG_WIDTH,
    parameter int VERTS_PER_PRIM  = 3,
    parameter int PRIM_FIFO_DEPTH = 4
) (
    input  logic                                   I_CLOCK,
    input  logic                                   I_RESET,
    input  logic                                   I_LOCK,
    input  logic [OPCODE_WIDTH-1:0]                I_Opcode,
    input  logic                                   I_PrimMode,
    input  logic [3:0]                             I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]                   I_DestValue,
    input  logic [VREG_ID_WIDTH-1:0]               I_DestVRegIdx,
    input  logic [VREG_WIDTH-1:0]                  I_VecDestValue,
    input  logic [VREG_WIDTH-1:0]                  I_VecSrc1Value,
    input  logic [2:0]                             I_CCValue,
    input  logic                                   I_RegWEn,
    input  logic                                   I_VRegWEn,
    input  logic                                   I_CCWEn,
    input  logic                                   I_GPUStallSignal,
    output logic                                   O_LOCK,
    output logic [3:0]                             O_WriteBackRegIdx,
    output logic [REG_WIDTH-1:0]                   O_WriteBackData,
    output logic [VREG_ID_WIDTH-1:0]               O_WriteBackVRegIdx,
    output logic [VREG_WIDTH-1:0]                  O_VecDestValue,
    output logic [2:0]                             O_CCValue,
    output logic                                   O_RegWEn,
    output logic                                   O_VRegWEn,
    output logic                                   O_CCWEn,
    output logic [VERTS_PER_PRIM*VERTEX_WIDTH-1:0] O_Prim,
    output logic                                   O_PrimValid,
    output logic                                   O_PrimFull,
    output logic                                   O_Overflow
);

    localparam int PRIM_WIDTH = VERTS_PER_PRIM * VERTEX_WIDTH;
    localparam int CNT_W      = $clog2(VERTS_PER_PRIM + 1);
    localparam int IDX_W      = (VERTS_PER_PRIM > 1) ? $clog2(VERTS_PER_PRIM) : 1;
    localparam int FIFO_CNT_W = $clog2(PRIM_FIFO_DEPTH) + 1;

    logic                    r_lock;
    logic [3:0]              r_regIdx;
    logic [REG_WIDTH-1:0]    r_regData;
    logic [VREG_ID_WIDTH-1:0] r_vregIdx;
    logic [VREG_WIDTH-1:0]   r_vecData;
    logic [2:0]              r_ccValue;
    logic                    r_regWEn;
    logic                    r_vregWEn;
    logic                    r_ccWEn;

    asm_state_e              r_state;
    logic                    r_mode;
    logic [CNT_W-1:0]        r_count;
    logic [VERTEX_WIDTH-1:0] r_slots [VERTS_PER_PRIM];
    logic                    r_overflow;

    logic [VERTEX_WIDTH-1:0] w_vertex;
    logic [VERTEX_WIDTH-1:0] w_assembled [VERTS_PER_PRIM];
    logic [PRIM_WIDTH-1:0]   w_primData;
    logic                    w_setVertex;
    logic                    w_lastVertex;
    logic                    w_pop;
    logic                    w_fifoFull;
    logic                    w_fifoEmpty;
    logic [FIFO_CNT_W-1:0]   w_fifoCount;
    logic                    w_drop;
    logic                    w_unusedSrc1Bits;

    assign w_vertex         = I_VecSrc1Value[VERTEX_WIDTH-1:0];
    assign w_unusedSrc1Bits = ^I_VecSrc1Value[VREG_WIDTH-1:VERTEX_WIDTH];
    assign w_setVertex      = I_LOCK && (r_state == ST_COLLECT) && (I_Opcode == OP_SETVERTEX);
    assign w_lastVertex     = w_setVertex && (r_count == CNT_W'(VERTS_PER_PRIM - 1));
    assign w_pop            = ~w_fifoEmpty & ~I_GPUStallSignal;
    assign w_drop           = w_lastVertex && (w_fifoCount == FIFO_CNT_W'(PRIM_FIFO_DEPTH)) && !w_pop;

    // The completing vertex always lands in the top slot, so the pushed
    // primitive is the stored slots with the incoming vertex on top.
    always_comb begin
        w_primData = '0;
        for (int i = 0; i < VERTS_PER_PRIM; i++) begin
            w_assembled[i] = r_slots[i];
        end
        w_assembled[VERTS_PER_PRIM-1] = w_vertex;
        for (int i = 0; i < VERTS_PER_PRIM; i++) begin
            w_primData[i*VERTEX_WIDTH +: VERTEX_WIDTH] = w_assembled[i];
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            r_lock    <= 1'b0;
            r_regIdx  <= '0;
            r_regData <= '0;
            r_vregIdx <= '0;
            r_vecData <= '0;
            r_ccValue <= '0;
            r_regWEn  <= 1'b0;
            r_vregWEn <= 1'b0;
            r_ccWEn   <= 1'b0;
        end else begin
            r_lock    <= I_LOCK;
            r_regIdx  <= I_DestRegIdx;
            r_regData <= I_DestValue;
            r_vregIdx <= I_DestVRegIdx;
            r_vecData <= I_VecDestValue;
            r_ccValue <= I_CCValue;
            r_regWEn  <= I_RegWEn & I_LOCK;
            r_vregWEn <= I_VRegWEn & I_LOCK;
            r_ccWEn   <= I_CCWEn & I_LOCK;
        end
    end

    // Strip mode keeps the last VERTS_PER_PRIM-1 vertices as the start of
    // the next primitive.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            r_state <= ST_IDLE;
            r_mode  <= PRIM_MODE_LIST;
            r_count <= '0;
            for (int i = 0; i < VERTS_PER_PRIM; i++) begin
                r_slots[i] <= '0;
            end
        end else if (I_LOCK) begin
            case (r_state)
                ST_IDLE: begin
                    if (I_Opcode == OP_BEGINPRIMITIVE) begin
                        r_state <= ST_COLLECT;
                        r_mode  <= I_PrimMode;
                        r_count <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (I_Opcode == OP_BEGINPRIMITIVE) begin
                        r_mode  <= I_PrimMode;
                        r_count <= '0;
                    end else if (I_Opcode == OP_ENDPRIMITIVE) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end else if (w_lastVertex) begin
                        if (r_mode == PRIM_MODE_STRIP && VERTS_PER_PRIM > 1) begin
                            for (int i = 0; i < VERTS_PER_PRIM - 1; i++) begin
                                r_slots[i] <= w_assembled[i+1];
                            end
                            r_count <= CNT_W'(VERTS_PER_PRIM - 1);
                        end else begin
                            r_count <= '0;
                        end
                    end else if (w_setVertex) begin
                        r_slots[r_count[IDX_W-1:0]] <= w_vertex;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    prim_fifo #(
        .WIDTH (PRIM_WIDTH),
        .DEPTH (PRIM_FIFO_DEPTH)
    ) u_primFifo (
        .i_clock (I_CLOCK),
        .i_reset (I_RESET),
        .i_push  (w_lastVertex),
        .i_pop   (w_pop),
        .i_data  (w_primData),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount),
        .o_head  (O_Prim)
    );

    assign O_LOCK             = r_lock;
    assign O_WriteBackRegIdx  = r_regIdx;
    assign O_WriteBackData    = r_regData;
    assign O_WriteBackVRegIdx = r_vregIdx;
    assign O_VecDestValue     = r_vecData;
    assign O_CCValue          = r_ccValue;
    assign O_RegWEn           = r_regWEn;
    assign O_VRegWEn          = r_vregWEn;
    assign O_CCWEn            = r_ccWEn;
    assign O_PrimValid        = ~w_fifoEmpty;
    assign O_PrimFull         = w_fifoFull;
    assign O_Overflow         = r_overflow;

endmodule

// File: tb/tb_writeback_prim_assembler.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// queue-based model of vertex assembly and the primitive FIFO.
module tb_writeback_prim_assembler;
    import writeback_prim_assembler_pkg::*;

    localparam int V     = 3;
    localparam int VW    = 30;
    localparam int DEPTH = 4;
    localparam int PW    = V * VW;

    logic          I_CLOCK;
    logic          I_RESET;
    logic          I_LOCK;
    logic [7:0]    I_Opcode;
    logic          I_PrimMode;
    logic [3:0]    I_DestRegIdx;
    logic [15:0]   I_DestValue;
    logic [5:0]    I_DestVRegIdx;
    logic [63:0]   I_VecDestValue;
    logic [63:0]   I_VecSrc1Value;
    logic [2:0]    I_CCValue;
    logic          I_RegWEn, I_VRegWEn, I_CCWEn;
    logic          I_GPUStallSignal;
    logic          O_LOCK;
    logic [3:0]    O_WriteBackRegIdx;
    logic [15:0]   O_WriteBackData;
    logic [5:0]    O_WriteBackVRegIdx;
    logic [63:0]   O_VecDestValue;
    logic [2:0]    O_CCValue;
    logic          O_RegWEn, O_VRegWEn, O_CCWEn;
    logic [PW-1:0] O_Prim;
    logic          O_PrimValid, O_PrimFull, O_Overflow;

    int nVectors;
    int nMiscompares;

    logic          eLock, eRegWEn, eVRegWEn, eCCWEn;
    logic [3:0]    eIdx;
    logic [15:0]   eData;
    logic [5:0]    eVIdx;
    logic [63:0]   eVec;
    logic [2:0]    eCC;

    bit            mActive;
    bit            mMode;
    logic [VW-1:0] mVerts[$];
    logic [PW-1:0] mFifo[$];
    bit            mOvf;

    writeback_prim_assembler dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_Opcode(I_Opcode),
        .I_PrimMode(I_PrimMode), .I_DestRegIdx(I_DestRegIdx), .I_DestValue(I_DestValue),
        .I_DestVRegIdx(I_DestVRegIdx), .I_VecDestValue(I_VecDestValue),
        .I_VecSrc1Value(I_VecSrc1Value), .I_CCValue(I_CCValue), .I_RegWEn(I_RegWEn),
        .I_VRegWEn(I_VRegWEn), .I_CCWEn(I_CCWEn), .I_GPUStallSignal(I_GPUStallSignal),
        .O_LOCK(O_LOCK), .O_WriteBackRegIdx(O_WriteBackRegIdx), .O_WriteBackData(O_WriteBackData),
        .O_WriteBackVRegIdx(O_WriteBackVRegIdx), .O_VecDestValue(O_VecDestValue),
        .O_CCValue(O_CCValue), .O_RegWEn(O_RegWEn), .O_VRegWEn(O_VRegWEn), .O_CCWEn(O_CCWEn),
        .O_Prim(O_Prim), .O_PrimValid(O_PrimValid), .O_PrimFull(O_PrimFull),
        .O_Overflow(O_Overflow)
    );

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    function automatic logic [PW-1:0] pack3(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                            input logic [VW-1:0] c);
        return {c, b, a};
    endfunction

    // Drives one instruction across one state-update edge and advances the model.
    task automatic applyStimulus(input bit rst, input bit lock, input logic [7:0] op,
                                 input bit mode, input logic [VW-1:0] vtx, input bit stall,
                                 input bit randWb);
        logic [PW-1:0] prim;
        bit done;
        bit popped;
        int sizeBefore;
        I_RESET = rst;
        I_LOCK = lock;
        I_Opcode = op;
        I_PrimMode = mode;
        I_GPUStallSignal = stall;
        I_VecSrc1Value = {$urandom, $urandom};
        I_VecSrc1Value[VW-1:0] = vtx;
        if (randWb) begin
            I_DestRegIdx = 4'($urandom);
            I_DestValue = 16'($urandom);
            I_DestVRegIdx = 6'($urandom);
            I_VecDestValue = {$urandom, $urandom};
            I_CCValue = 3'($urandom);
            I_RegWEn = 1'($urandom);
            I_VRegWEn = 1'($urandom);
            I_CCWEn = 1'($urandom);
        end
        if (rst) begin
            {eLock, eRegWEn, eVRegWEn, eCCWEn} = '0;
            eIdx = '0; eData = '0; eVIdx = '0; eVec = '0; eCC = '0;
            mActive = 0; mMode = 0; mOvf = 0;
            mVerts.delete();
            mFifo.delete();
        end else begin
            eLock = lock; eIdx = I_DestRegIdx; eData = I_DestValue; eVIdx = I_DestVRegIdx;
            eVec = I_VecDestValue; eCC = I_CCValue;
            eRegWEn = I_RegWEn & lock; eVRegWEn = I_VRegWEn & lock; eCCWEn = I_CCWEn & lock;
            popped = (mFifo.size() > 0) && !stall;
            done = 0;
            prim = '0;
            if (lock) begin
                if (op == OP_BEGINPRIMITIVE) begin
                    mActive = 1; mMode = mode; mVerts.delete();
                end else if (mActive && op == OP_ENDPRIMITIVE) begin
                    mActive = 0; mVerts.delete();
                end else if (mActive && op == OP_SETVERTEX) begin
                    mVerts.push_back(vtx);
                    if (mVerts.size() == V) begin
                        for (int i = 0; i < V; i++) prim[i*VW +: VW] = mVerts[i];
                        done = 1;
                        if (mMode) void'(mVerts.pop_front());
                        else mVerts.delete();
                    end
                end
            end
            sizeBefore = mFifo.size();
            if (popped) void'(mFifo.pop_front());
            if (done) begin
                if (sizeBefore == DEPTH && !popped) mOvf = 1;
                else mFifo.push_back(prim);
            end
        end
        @(negedge I_CLOCK);
        @(posedge I_CLOCK);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1, 1, OP_BEGINPRIMITIVE, 1, 30'h1234, 0, 1);
        nVectors += 4;
        if (O_LOCK !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_lock: got %0h expected 0", O_LOCK); end
        if (O_WriteBackData !== 16'h0) begin nMiscompares++; $display("[TB] FAIL reset_data: got %0h expected 0", O_WriteBackData); end
        if ({O_RegWEn, O_VRegWEn, O_CCWEn} !== 3'b000) begin nMiscompares++; $display("[TB] FAIL reset_wen: got %0b expected 000", {O_RegWEn, O_VRegWEn, O_CCWEn}); end
        if ({O_Prim, O_PrimValid, O_PrimFull, O_Overflow} !== '0) begin nMiscompares++; $display("[TB] FAIL reset_prim: got %0h/%0b%0b%0b expected 0", O_Prim, O_PrimValid, O_PrimFull, O_Overflow); end
    endtask

    task automatic test_writeback();
        applyStimulus(1, 0, OP_NOP, 0, '0, 1, 1);
        I_DestRegIdx = 4'h5; I_DestValue = 16'hBEEF; I_DestVRegIdx = 6'h2A;
        I_VecDestValue = 64'h0123_4567_89AB_CDEF; I_CCValue = 3'b101;
        I_RegWEn = 1; I_VRegWEn = 1; I_CCWEn = 1;
        applyStimulus(0, 0, OP_NOP, 0, '0, 1, 0);
        nVectors += 3;
        if ({O_RegWEn, O_VRegWEn, O_CCWEn} !== 3'b000) begin nMiscompares++; $display("[TB] FAIL wb_unlocked_wen: got %0b expected 000", {O_RegWEn, O_VRegWEn, O_CCWEn}); end
        if (O_WriteBackData !== 16'hBEEF) begin nMiscompares++; $display("[TB] FAIL wb_unlocked_data: got %0h expected beef", O_WriteBackData); end
        if (O_LOCK !== 1'b0) begin nMiscompares++; $display("[TB] FAIL wb_unlocked_lock: got %0h expected 0", O_LOCK); end
        applyStimulus(0, 1, OP_NOP, 0, '0, 1, 0);
        nVectors += 4;
        if (O_WriteBackData !== 16'hBEEF || O_RegWEn !== 1'b1) begin nMiscompares++; $display("[TB] FAIL wb_locked: got data %0h wen %0b expected beef 1", O_WriteBackData, O_RegWEn); end
        if (O_WriteBackRegIdx !== 4'h5 || O_WriteBackVRegIdx !== 6'h2A) begin nMiscompares++; $display("[TB] FAIL wb_idx: got %0h/%0h expected 5/2a", O_WriteBackRegIdx, O_WriteBackVRegIdx); end
        if (O_VecDestValue !== 64'h0123_4567_89AB_CDEF || O_CCValue !== 3'b101) begin nMiscompares++; $display("[TB] FAIL wb_vec_cc: got %0h/%0b expected 123456789abcdef/101", O_VecDestValue, O_CCValue); end
        if ({O_LOCK, O_VRegWEn, O_CCWEn} !== 3'b111) begin nMiscompares++; $display("[TB] FAIL wb_locked_flags: got %0b expected 111", {O_LOCK, O_VRegWEn, O_CCWEn}); end
    endtask

    task automatic test_list();
        logic [PW-1:0] expPrim;
        expPrim = pack3(30'h1, 30'h2, 30'h3);
        applyStimulus(1, 0, OP_NOP, 0, '0, 1, 1);
        applyStimulus(0, 1, OP_BEGINPRIMITIVE, 0, '0, 1, 1);
        applyStimulus(0, 1, OP_SETVERTEX, 0, 30'h1, 1, 1);
        applyStimulus(0, 1, OP_SETVERTEX, 0, 30'h2, 1, 1);
        nVectors++;
        if (O_PrimValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL list_early_valid: got %0b expected 0", O_PrimValid); end
        applyStimulus(0, 1, OP_SETVERTEX, 0, 30'h3, 1, 1);
        nVectors += 2;
        if (O_PrimValid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL list_valid: got %0b expected 1", O_PrimValid); end
        if (O_Prim !== expPrim) begin nMiscompares++; $display("[TB] FAIL list_prim: got %0h expected %0h", O_Prim, expPrim); end
        applyStimulus(0, 1, OP_NOP, 0, '0, 0, 1);
        nVectors++;
        if (O_PrimValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL list_pop: got %0b expected 0", O_PrimValid); end
    endtask

    task automatic test_strip();
        logic [PW-1:0] expPrim;
        applyStimulus(1, 0, OP_NOP, 0, '0, 1, 1);
        applyStimulus(0, 1, OP_BEGINPRIMITIVE, 1, '0, 1, 1);
        for (int k = 1; k <= 5; k++) applyStimulus(0, 1, OP_SETVERTEX, 0, VW'(k), 1, 1);
        for (int k = 0; k < 3; k++) begin
            expPrim = pack3(VW'(k + 1), VW'(k + 2), VW'(k + 3));
            nVectors++;
            if (O_Prim !== expPrim || O_PrimValid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL strip_prim%0d: got %0h valid %0b expected %0h", k, O_Prim, O_PrimValid, expPrim); end
            applyStimulus(0, 1, OP_NOP, 0, '0, 0, 1);
        end
        nVectors++;
        if (O_PrimValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL strip_drained: got %0b expected 0", O_PrimValid); end
    endtask

    task automatic test_overflow();
        logic [PW-1:0] rec [5];
        logic [VW-1:0] v [3];
        applyStimulus(1, 0, OP_NOP, 0, '0, 1, 1);
        applyStimulus(0, 1, OP_BEGINPRIMITIVE, 0, '0, 1, 1);
        for (int p = 0; p < 5; p++) begin
            for (int j = 0; j < 3; j++) begin
                v[j] = VW'($urandom);
                applyStimulus(0, 1, OP_SETVERTEX, 0, v[j], 1, 1);
            end
            rec[p] = pack3(v[0], v[1], v[2]);
            if (p == 3) begin
                nVectors += 2;
                if (O_PrimFull !== 1'b1) begin nMiscompares++; $display("[TB] FAIL ovf_full: got %0b expected 1", O_PrimFull); end
                if (O_Overflow !== 1'b0) begin nMiscompares++; $display("[TB] FAIL ovf_early: got %0b expected 0", O_Overflow); end
            end
        end
        nVectors++;
        if (O_Overflow !== 1'b1) begin nMiscompares++; $display("[TB] FAIL ovf_set: got %0b expected 1", O_Overflow); end
        for (int k = 0; k < 4; k++) begin
            nVectors++;
            if (O_Prim !== rec[k] || O_PrimValid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL ovf_pop%0d: got %0h valid %0b expected %0h", k, O_Prim, O_PrimValid, rec[k]); end
            applyStimulus(0, 1, OP_NOP, 0, '0, 0, 1);
        end
        nVectors += 2;
        if (O_PrimValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL ovf_drained: got %0b expected 0", O_PrimValid); end
        if (O_Overflow !== 1'b1) begin nMiscompares++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", O_Overflow); end
    endtask

    task automatic test_push_pop_full();
        logic [PW-1:0] rec [4];
        logic [VW-1:0] v [3];
        applyStimulus(1, 0, OP_NOP, 0, '0, 1, 1);
        applyStimulus(0, 1, OP_BEGINPRIMITIVE, 0, '0, 1, 1);
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 3; j++) begin
                v[j] = VW'($urandom);
                applyStimulus(0, 1, OP_SETVERTEX, 0, v[j], 1, 1);
            end
            rec[p] = pack3(v[0], v[1], v[2]);
        end
        applyStimulus(0, 1, OP_SETVERTEX, 0, VW'($urandom), 1, 1);
        applyStimulus(0, 1, OP_SETVERTEX, 0, VW'($urandom), 1, 1);
        applyStimulus(0, 1, OP_SETVERTEX, 0, VW'($urandom), 0, 1);
        nVectors += 3;
        if (O_PrimFull !== 1'b1) begin nMiscompares++; $display("[TB] FAIL pp_full: got %0b expected 1", O_PrimFull); end
        if (O_Overflow !== 1'b0) begin nMiscompares++; $display("[TB] FAIL pp_ovf: got %0b expected 0", O_Overflow); end
        if (O_Prim !== rec[1]) begin nMiscompares++; $display("[TB] FAIL pp_head: got %0h expected %0h", O_Prim, rec[1]); end
    endtask

    task automatic test_abort();
        logic [PW-1:0] expPrim;
        applyStimulus(1, 0, OP_NOP, 0, '0, 1, 1);
        applyStimulus(0, 1, OP_BEGINPRIMITIVE, 0, '0, 1, 1);
        applyStimulus(0, 1, OP_SETVERTEX, 0, 30'h11, 1, 1);
        applyStimulus(0, 1, OP_SETVERTEX, 0, 30'h12, 1, 1);
        applyStimulus(0, 1, OP_ENDPRIMITIVE, 0, '0, 1, 1);
        for (int j = 0; j < 3; j++) applyStimulus(0, 1, OP_SETVERTEX, 0, VW'(j + 7), 1, 1);
        nVectors++;
        if (O_PrimValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL abort_end: got %0b expected 0", O_PrimValid); end
        applyStimulus(0, 1, OP_BEGINPRIMITIVE, 1, '0, 1, 1);
        applyStimulus(0, 1, OP_SETVERTEX, 0, 30'h21, 1, 1);
        applyStimulus(0, 1, OP_SETVERTEX, 0, 30'h22, 1, 1);
        applyStimulus(0, 1, OP_SETVERTEX, 0, 30'h23, 1, 1);
        expPrim = pack3(30'h21, 30'h22, 30'h23);
        nVectors++;
        if (O_Prim !== expPrim) begin nMiscompares++; $display("[TB] FAIL abort_restart: got %0h expected %0h", O_Prim, expPrim); end
        applyStimulus(0, 1, OP_BEGINPRIMITIVE, 0, '0, 1, 1);
        applyStimulus(0, 1, OP_SETVERTEX, 0, 30'h31, 1, 1);
        applyStimulus(1, 1, OP_SETVERTEX, 0, 30'h32, 1, 1);
        nVectors += 2;
        if ({O_Prim, O_PrimValid, O_PrimFull, O_Overflow} !== '0) begin nMiscompares++; $display("[TB] FAIL abort_reset_prim: got %0h/%0b expected 0", O_Prim, O_PrimValid); end
        if ({O_LOCK, O_RegWEn, O_VRegWEn, O_CCWEn, O_WriteBackData} !== '0) begin nMiscompares++; $display("[TB] FAIL abort_reset_wb: got %0b/%0h expected 0", O_LOCK, O_WriteBackData); end
        for (int j = 0; j < 3; j++) applyStimulus(0, 1, OP_SETVERTEX, 0, VW'(j + 1), 1, 1);
        nVectors++;
        if (O_PrimValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL abort_idle: got %0b expected 0", O_PrimValid); end
    endtask

    task automatic test_random();
        logic [7:0] op;
        logic [PW-1:0] eHead;
        int r;
        applyStimulus(1, 0, OP_NOP, 0, '0, 1, 1);
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(9, 0));
            op = (r == 0) ? OP_BEGINPRIMITIVE : (r == 1) ? OP_ENDPRIMITIVE :
                 (r <= 7) ? OP_SETVERTEX : 8'($urandom);
            applyStimulus(($urandom_range(99, 0) == 0), ($urandom_range(9, 0) < 8), op,
                          1'($urandom), VW'($urandom), ($urandom_range(9, 0) < 5), 1);
            eHead = (mFifo.size() > 0) ? mFifo[0] : '0;
            nVectors += 4;
            if ({O_LOCK, O_WriteBackRegIdx, O_WriteBackData, O_WriteBackVRegIdx, O_CCValue} !== {eLock, eIdx, eData, eVIdx, eCC}) begin nMiscompares++; $display("[TB] FAIL rnd_wb@%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", n, O_WriteBackRegIdx, O_WriteBackData, O_WriteBackVRegIdx, eIdx, eData, eVIdx); end
            if (O_VecDestValue !== eVec || {O_RegWEn, O_VRegWEn, O_CCWEn} !== {eRegWEn, eVRegWEn, eCCWEn}) begin nMiscompares++; $display("[TB] FAIL rnd_vec_wen@%0d: got %0h/%0b expected %0h/%0b", n, O_VecDestValue, {O_RegWEn, O_VRegWEn, O_CCWEn}, eVec, {eRegWEn, eVRegWEn, eCCWEn}); end
            if (O_Prim !== eHead) begin nMiscompares++; $display("[TB] FAIL rnd_prim@%0d: got %0h expected %0h", n, O_Prim, eHead); end
            if ({O_PrimValid, O_PrimFull, O_Overflow} !== {(mFifo.size() > 0), (mFifo.size() == DEPTH), mOvf}) begin nMiscompares++; $display("[TB] FAIL rnd_flags@%0d: got %0b expected %0b", n, {O_PrimValid, O_PrimFull, O_Overflow}, {(mFifo.size() > 0), (mFifo.size() == DEPTH), mOvf}); end
        end
    endtask

    initial begin
        nVectors = 0;
        nMiscompares = 0;
        test_reset();
        test_writeback();
        test_list();
        test_strip();
        test_overflow();
        test_push_pop_full();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
